// File: rtl/vector_scale.sv
// vector_scale: broadcast a signed scalar across a signed vector,
// saturating each product; TILING lanes per cycle, one valid pulse per op.
module vector_scale #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 10,
  parameter int TILING            = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [A_CELL_WIDTH-1:0]                 a,
  input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                    valid,
  output logic                                    error,
  output logic                                    busy
);

  localparam int AW = A_CELL_WIDTH;
  localparam int BW = B_CELL_WIDTH;
  localparam int RW = RESULT_CELL_WIDTH;
  localparam int PW = AW + BW;
  localparam int P  = (VECTOR_LEN + TILING - 1) / TILING;
  localparam int TW = (P > 1) ? $clog2(P) : 1;

  localparam logic [TW-1:0] LAST = TW'(P - 1);

  // Clamp bounds expressed at full product width.
  localparam logic signed [PW-1:0] MAXV =
    $signed({{(PW-RW+1){1'b0}}, {(RW-1){1'b1}}});
  localparam logic signed [PW-1:0] MINV =
    $signed({{(PW-RW+1){1'b1}}, {(RW-1){1'b0}}});

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                     state_q, state_d;
  logic [TW-1:0]              tile_q, tile_d;
  logic signed [AW-1:0]       a_q, a_d;
  logic [VECTOR_LEN*BW-1:0]   b_q, b_d;
  logic [VECTOR_LEN*RW-1:0]   result_q, result_d;
  logic                       valid_q, valid_d;
  logic                       error_q, error_d;
  logic                       acc_q, acc_d;
  logic                       busy_q, busy_d;

  always_comb begin : next_c
    int                     idx;
    logic signed [BW-1:0]   elem;
    logic signed [PW-1:0]   prod;
    logic [RW-1:0]          sat;
    logic                   clip;

    idx      = 0;
    elem     = '0;
    prod     = '0;
    sat      = '0;
    clip     = 1'b0;
    state_d  = state_q;
    tile_d   = tile_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    valid_d  = 1'b0;
    error_d  = error_q;
    acc_d    = acc_q;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = $signed(a);
          b_d     = b;
          acc_d   = 1'b0;
          error_d = 1'b0;
          tile_d  = '0;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < TILING; k++) begin
          idx = int'(tile_q) * TILING + k;
          if (idx < VECTOR_LEN) begin
            elem = $signed(b_q[idx*BW +: BW]);
            prod = PW'(a_q) * PW'(elem);
            clip = 1'b1;
            if (prod > MAXV) begin
              sat = MAXV[RW-1:0];
            end else if (prod < MINV) begin
              sat = MINV[RW-1:0];
            end else begin
              sat  = prod[RW-1:0];
              clip = 1'b0;
            end
            result_d[idx*RW +: RW] = sat;
            acc_d = acc_d | clip;
          end
        end
        if (tile_q == LAST) begin
          valid_d = 1'b1;
          error_d = acc_d;
          busy_d  = 1'b0;
          tile_d  = '0;
          state_d = IDLE;
        end else begin
          tile_d = tile_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tile_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      acc_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tile_q   <= tile_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign error  = error_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_vector_scale.sv
// tb_vector_scale: table vectors, corner sequences and random ops
// against a plain-arithmetic model, on TILING=5 and TILING=2 instances.
module tb_vector_scale;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [7:0]  a;
  logic [39:0] b;
  logic [49:0] res0, res1;
  logic        val0, val1, err0, err1, bsy0, bsy1;
  logic        sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vector_scale u_d5 (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
    .result(res0), .valid(val0), .error(err0), .busy(bsy0)
  );

  vector_scale #(.TILING(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
    .result(res1), .valid(val1), .error(err1), .busy(bsy1)
  );

  wire [49:0] res_w = sel ? res1 : res0;
  wire        val_w = sel ? val1 : val0;
  wire        err_w = sel ? err1 : err0;
  wire        bsy_w = sel ? bsy1 : bsy0;

  typedef struct packed {
    logic [7:0]  a;
    logic [39:0] b;
    logic [49:0] r;
    logic        e;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [39:0] pb(input int e4, input int e3,
      input int e2, input int e1, input int e0);
    return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [49:0] pr(input int e4, input int e3,
      input int e2, input int e1, input int e0);
    return {10'(e4), 10'(e3), 10'(e2), 10'(e1), 10'(e0)};
  endfunction

  function automatic void model(input logic [7:0] av, input logic [39:0] bv,
      output logic [49:0] r, output logic e);
    int p;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p = int'($signed(av)) * int'($signed(bv[i*8 +: 8]));
      if (p > 511) begin p = 511; e = 1'b1; end
      if (p < -512) begin p = -512; e = 1'b1; end
      r[i*10 +: 10] = p[9:0];
    end
  endfunction

  task automatic rand_ab();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    a = t[7:0];
    b = t[47:8];
  endtask

  // One operation on the selected instance; reports latency in edges.
  task automatic do_op(input logic which, input logic [7:0] av,
      input logic [39:0] bv, output logic [49:0] r, output logic e,
      output int lat, output int bcnt, output logic bz,
      output logic v_after, output logic e_after);
    lat = -1; bcnt = 0; r = '0; e = 1'b0; bz = 1'b1;
    v_after = 1'b1; e_after = 1'b0;
    @(negedge clk);
    sel = which;
    a = av;
    b = bv;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    rand_ab();
    if (bsy_w) bcnt++;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (val_w) begin
        lat = c; r = res_w; e = err_w; bz = bsy_w;
        break;
      end
      if (bsy_w) bcnt++;
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      v_after = val_w;
      e_after = err_w;
    end
  endtask

  task automatic check_op(input string nm, input logic which,
      input logic [7:0] av, input logic [39:0] bv,
      input logic [49:0] er, input logic ee);
    logic [49:0] r;
    logic        e, bz, va, ea;
    int          lat, bc, pexp;
    pexp = which ? 3 : 1;
    do_op(which, av, bv, r, e, lat, bc, bz, va, ea);
    chk({nm, "_lat"}, 64'(lat), 64'(pexp));
    if (lat > 0) begin
      chk({nm, "_res"}, 64'(r), 64'(er));
      chk({nm, "_err"}, 64'(e), 64'(ee));
      chk({nm, "_busycnt"}, 64'(bc), 64'(pexp));
      chk({nm, "_busy_end"}, 64'(bz), 64'(0));
      chk({nm, "_valid_pulse"}, 64'(va), 64'(0));
      chk({nm, "_err_hold"}, 64'(ea), 64'(ee));
    end
  endtask

  vec_t tbl[5];

  initial begin
    logic [49:0] mr;
    logic        me;
    logic [49:0] first_r;
    int          nval;

    tbl[0] = '{a: 8'(3), b: pb(5, 4, 3, 2, 1),
               r: pr(15, 12, 9, 6, 3), e: 1'b0};
    tbl[1] = '{a: 8'(-2), b: pb(10, -20, 1, 100, 0),
               r: pr(-20, 40, -2, -200, 0), e: 1'b0};
    tbl[2] = '{a: 8'(100), b: pb(50, 4, 30, 2, -50),
               r: pr(511, 400, 511, 200, -512), e: 1'b1};
    tbl[3] = '{a: 8'(3), b: pb(5, 4, 3, 2, 1),
               r: pr(15, 12, 9, 6, 3), e: 1'b0};
    tbl[4] = '{a: 8'(1), b: pb(1, 2, 3, 4, 5),
               r: pr(1, 2, 3, 4, 5), e: 1'b0};

    sel = 1'b0; start0 = 1'b0; start1 = 1'b0;
    a = '0; b = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res0", 64'(res0), 64'(0));
    chk("rst_flags0", 64'({val0, err0, bsy0}), 64'(0));
    chk("rst_res1", 64'(res1), 64'(0));
    chk("rst_flags1", 64'({val1, err1, bsy1}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 5; i++)
        check_op($sformatf("tbl%0d_t%0d", i, w), w[0], tbl[i].a,
                 tbl[i].b, tbl[i].r, tbl[i].e);

    // Start held through the busy window, incl. the completing edge.
    @(negedge clk);
    sel = 1'b1; a = 8'(1); b = pb(1, 2, 3, 4, 5); start1 = 1'b1;
    @(posedge clk);
    #1;
    a = 8'(7);
    b = pb(9, 9, 9, 9, 9);
    nval = 0; first_r = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) start1 = 1'b0;
      if (val1) begin
        nval++;
        if (nval == 1) first_r = res1;
        chk("ign_lat", 64'(c), 64'(3));
      end
    end
    chk("ign_nvalid", 64'(nval), 64'(1));
    chk("ign_res", 64'(first_r), 64'(pr(1, 2, 3, 4, 5)));
    chk("ign_idle", 64'(bsy1), 64'(0));

    // Reset in the middle of a multi-pass operation.
    @(negedge clk);
    a = 8'(-5); b = pb(1, 2, 3, 4, 5); start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_res", 64'(res1), 64'(0));
    chk("mid_rst_flags", 64'({val1, err1, bsy1}), 64'(0));
    chk("mid_rst_res0", 64'(res0), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    nval = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (val1) nval++;
    end
    chk("mid_rst_novalid", 64'(nval), 64'(0));
    check_op("after_rst", 1'b1, 8'(-3), pb(-100, 3, 0, -1, 127),
             pr(300, -9, 0, 3, -381), 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [7:0]  ra;
      logic [39:0] rb;
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      ra = t[7:0];
      rb = t[47:8];
      if (i % 7 == 0) ra = 8'h80;
      if (i % 11 == 0) rb[7:0] = 8'h80;
      model(ra, rb, mr, me);
      check_op($sformatf("rnd%0d", i), i[0], ra, rb, mr, me);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
